io_peripheral: RTL

// - Board-side counterpart of the 8-bit core's I/O pins. Consumes the core's

---
 rtl/io_peripheral_pkg.sv | 29 ++
 rtl/io_peripheral_if.sv | 12 +
 rtl/io_peripheral_btn_debounce.sv | 51 +++++
 rtl/io_peripheral.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/io_peripheral_pkg.sv
// Shared types and helpers for the board-side I/O peripheral.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: interrupt FSM encoding, event-code layout and builder, counter width helper.
package io_periph_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_GAP    = 2'd2
  } irq_state_t;

  // Bit 7 marks a valid event so a code can never read as the idle value 0x00.
  localparam int EVT_VALID_BIT = 7;

  // Bits needed to hold the values 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [7:0] evt_code(input logic [2:0] idx);
    logic [7:0] code;
    code                = 8'h00;
    code[EVT_VALID_BIT] = 1'b1;
    code[2:0]           = idx;
    return code;
  endfunction

endpackage

// File: rtl/io_peripheral_if.sv
// Core-side bus of the I/O peripheral: data out of the core, event code and interrupt back in.
// Latency: n/a (wiring only).
// Backpressure: none; cpu_data_out has no strobe and the interrupt is a fire-and-forget pulse.
// Ports: master = core (drives cpu_data_out), slave = peripheral (drives cpu_data_in, cpu_interrupt).
interface io_peripheral_if;
  logic [7:0] cpu_data_out;
  logic [7:0] cpu_data_in;
  logic       cpu_interrupt;

  modport master (output cpu_data_out, input cpu_data_in, input cpu_interrupt);
  modport slave  (input cpu_data_out, output cpu_data_in, output cpu_interrupt);
endinterface

// File: rtl/io_peripheral_btn_debounce.sv
// One push-button: 2-FF synchroniser, stable-level debounce counter, press (rise) pulse.
// Latency: raw edge to rise pulse = 2 sync cycles + DEBOUNCE_CYCLES cycles.
// Backpressure: none; rise is a single-cycle pulse the consumer must capture.
// Ports: clk, reset (sync, high), btn_raw (async in), rise (one-cycle pulse on accepted press).
module btn_debounce
  import io_periph_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic rise
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic          level_q;
  logic [CW-1:0] cnt_q;
  logic          flip;

  // The count only advances while the synchronised input disagrees with the
  // accepted level; reaching the last count means it has disagreed for
  // DEBOUNCE_CYCLES consecutive cycles.
  assign flip = (sync_q2 != level_q) && (cnt_q == CNT_LAST);
  assign rise = flip && sync_q2;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
      if (sync_q2 == level_q) begin
        cnt_q <= '0;               // bounce back to old level restarts the count
      end else if (flip) begin
        level_q <= sync_q2;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/io_peripheral.sv
// Board-side I/O: glitch-filtered LED capture with blink, debounced button presses queued as interrupt events.
// Latency: LED value 2 cycles after it settles; press event 1 cycle arbiter + >=1 cycle FSM after debounce.
// Backpressure: full event queue stalls the arbiter, presses wait in per-button pending flags (re-press merges).
// Ports: clk, reset (sync, high), bus (slave: cpu_data_out in, cpu_data_in/cpu_interrupt out),
//        btn[NUM_BTN] raw buttons, blink_en, led[8].
module io_peripheral
  import io_periph_pkg::*;
#(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int FIFO_DEPTH      = 4,
  parameter int INT_GAP         = 4,
  parameter int BLINK_DIV       = 500
) (
  input  logic               clk,
  input  logic               reset,
  io_peripheral_if.slave     bus,
  input  logic [NUM_BTN-1:0] btn,
  input  logic               blink_en,
  output logic [7:0]         led
);

  localparam int            PW        = cnt_width(FIFO_DEPTH);
  localparam int            OW        = cnt_width(FIFO_DEPTH + 1);
  localparam int            GW        = cnt_width(INT_GAP);
  localparam int            BW        = cnt_width(BLINK_DIV);
  localparam logic [OW-1:0] OCC_FULL  = OW'(FIFO_DEPTH);
  localparam logic [GW-1:0] GAP_LAST  = GW'(INT_GAP - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  // ---------------- LED capture and blink ----------------
  logic [7:0]    prev_q;
  logic [7:0]    led_q;
  logic [BW-1:0] presc_q;
  logic          phase_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q  <= 8'h00;
      led_q   <= 8'h00;
      presc_q <= '0;
      phase_q <= 1'b1;
    end else begin
      prev_q <= bus.cpu_data_out;
      // The core has no write strobe: only a value seen on two consecutive
      // cycles is taken, so single-cycle bus transients never reach the LEDs.
      if ((bus.cpu_data_out == prev_q) && (bus.cpu_data_out != led_q)) begin
        led_q <= bus.cpu_data_out;
      end
      if (presc_q == BLINK_LAST) begin
        presc_q <= '0;
        phase_q <= ~phase_q;
      end else begin
        presc_q <= presc_q + BW'(1);
      end
    end
  end

  assign led = (blink_en && !phase_q) ? 8'h00 : led_q;

  // ---------------- Button debounce ----------------
  logic [NUM_BTN-1:0] rise_vec;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk    (clk),
      .reset  (reset),
      .btn_raw(btn[g]),
      .rise   (rise_vec[g])
    );
  end

  // ---------------- Pending flags and push arbiter ----------------
  logic [NUM_BTN-1:0] pending_q;
  logic [NUM_BTN-1:0] pending_d;
  logic [NUM_BTN-1:0] push_onehot;
  logic [2:0]         push_idx;
  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;

  // Descending scan so the lowest pending index is the one left selected.
  always_comb begin
    push_idx    = 3'd0;
    push_onehot = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        push_idx       = 3'(i);
        push_onehot    = '0;
        push_onehot[i] = 1'b1;
      end
    end
  end

  assign push = (|pending_q) && !fifo_full;

  // Clear before set: a press landing in the cycle its earlier event is being
  // queued is a fresh event, not a merge.
  always_comb begin
    pending_d = pending_q;
    if (push) begin
      pending_d = pending_d & ~push_onehot;
    end
    pending_d = pending_d | rise_vec;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // ---------------- Event FIFO ----------------
  // Storage is rounded to 2**PW entries so pointers wrap naturally; occupancy
  // still limits it to FIFO_DEPTH.
  logic [2:0]    fifo_mem [2**PW];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [OW-1:0] occ_q;
  logic [2:0]    head_idx;

  assign fifo_full  = (occ_q == OCC_FULL);
  assign fifo_empty = (occ_q == '0);
  assign head_idx   = fifo_mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= push_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   occ_q <= occ_q + OW'(1);
        2'b01:   occ_q <= occ_q - OW'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  // ---------------- Interrupt FSM ----------------
  irq_state_t    state_q;
  irq_state_t    state_d;
  logic [GW-1:0] gap_q;
  logic [GW-1:0] gap_d;
  logic [7:0]    data_in_q;

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_ASSERT;
      end
      ST_ASSERT: begin
        state_d = ST_GAP;
        gap_d   = '0;
      end
      ST_GAP: begin
        // Leaving straight to ASSERT from the last gap cycle keeps queued
        // events exactly 1+INT_GAP cycles apart.
        if (gap_q == GAP_LAST) begin
          state_d = fifo_empty ? ST_IDLE : ST_ASSERT;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pop = (state_q == ST_ASSERT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      gap_q     <= '0;
      data_in_q <= 8'h00;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      // Loaded on entry so the code is already valid during the pulse, then
      // held until the next event for a late read by the core.
      if (state_d == ST_ASSERT) begin
        data_in_q <= evt_code(head_idx);
      end
    end
  end

  assign bus.cpu_interrupt = (state_q == ST_ASSERT);
  assign bus.cpu_data_in   = data_in_q;

endmodule
